// File: rtl/rf_multiport_pkg.sv
// Shared definitions for the multi-port register file: default widths and FSM encodings.
// Optional shadow bank is enabled by defining RF_SHADOW_BANK_EN.
package rf_multiport_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    typedef logic [0:0] rf_state_t;

    localparam logic [0:0] RF_ST_CLR = 1'b0;
    localparam logic [0:0] RF_ST_RUN = 1'b1;

endpackage

// File: rtl/rf_read_port.sv
// One read port: registered address with stall hold and zero/bypass/array priority mux.
// Bank select logic exists only when RF_SHADOW_BANK_EN is defined.
module rf_read_port
    import rf_multiport_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              hold_i,
`ifdef RF_SHADOW_BANK_EN
    input  logic              bank_i,
    input  logic              wr_bank_i,
    output logic              rbank_o,
`endif
    input  logic              force_zero_i,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0] arr_data_i,
    output logic [ADDR_W-1:0] raddr_o,
    output logic [DATA_W-1:0] rdata_c_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hit;

    always_comb begin
        addr_d = hold_i ? addr_q : addr_i;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

`ifdef RF_SHADOW_BANK_EN
    logic bank_q, bank_d;

    always_comb begin
        bank_d = hold_i ? bank_q : bank_i;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= 1'b0;
        end else begin
            bank_q <= bank_d;
        end
    end

    assign rbank_o = bank_q;
    assign hit     = wr_valid_i && (wr_addr_i == addr_q) && (wr_bank_i == bank_q);
`else
    assign hit     = wr_valid_i && (wr_addr_i == addr_q);
`endif

    assign raddr_o = addr_q;

    // Clearing forces zero; then hardwired r0, then write-stage bypass, then array.
    always_comb begin
        rdata_c_o = arr_data_i;
        if (force_zero_i) begin
            rdata_c_o = '0;
        end else if ((ZERO_REG != 0) && (addr_q == '0)) begin
            rdata_c_o = '0;
        end else if (hit) begin
            rdata_c_o = wr_data_i;
        end
    end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised multi-read-port register file with write bypass and hardware clear sweep.
// Define RF_SHADOW_BANK_EN to add a second bank selected by bank_sel.
module rf_multiport
    import rf_multiport_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned N_RD     = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    input  logic                     rd_hold,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
`ifdef RF_SHADOW_BANK_EN
    input  logic                     bank_sel,
`endif
    output logic                     ready
);

    localparam int unsigned       DEPTH       = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] SWEEP_FIRST = (ZERO_REG != 0) ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] SWEEP_LAST  = ADDR_W'(DEPTH - 1);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              sweep_we;
    logic              clearing;

    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              zero_hit;

    logic [DATA_W-1:0] mem0 [DEPTH];

    // Clear sequencer and write-stage state.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RF_ST_CLR;
            idx_q      <= SWEEP_FIRST;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign zero_hit = (ZERO_REG != 0) && (wr_addr == '0);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sweep_we   = 1'b0;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            RF_ST_CLR: begin
                sweep_we = 1'b1;
                idx_d    = idx_q + ADDR_W'(1);
                if (idx_q == SWEEP_LAST) begin
                    state_d = RF_ST_RUN;
                end
            end
            RF_ST_RUN: begin
                idx_d = SWEEP_FIRST;
                if (clr_req) begin
                    state_d = RF_ST_CLR;
                end else if (wr_en && !zero_hit) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = wr_addr;
                    wr_data_d  = wr_data;
                end
            end
            default: begin
                state_d = RF_ST_CLR;
                idx_d   = SWEEP_FIRST;
            end
        endcase
    end

    assign clearing = (state_q == RF_ST_CLR);
    assign ready    = (state_q == RF_ST_RUN);

`ifdef RF_SHADOW_BANK_EN
    logic              wr_bank_q, wr_bank_d;
    logic [DATA_W-1:0] mem1 [DEPTH];

    always_comb begin
        wr_bank_d = wr_bank_q;
        if (wr_valid_d) begin
            wr_bank_d = bank_sel;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
        end
    end

    // Commit and sweep never coincide: the stage is invalid whenever the sweep runs.
    always_ff @(posedge clock) begin
        if (wr_valid_q && !wr_bank_q) begin
            mem0[wr_addr_q] <= wr_data_q;
        end
        if (wr_valid_q && wr_bank_q) begin
            mem1[wr_addr_q] <= wr_data_q;
        end
        if (sweep_we) begin
            mem0[idx_q] <= '0;
            mem1[idx_q] <= '0;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (wr_valid_q) begin
            mem0[wr_addr_q] <= wr_data_q;
        end
        if (sweep_we) begin
            mem0[idx_q] <= '0;
        end
    end
`endif

    for (genvar k = 0; k < int'(N_RD); k++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] arr_data;
`ifdef RF_SHADOW_BANK_EN
        logic              rbank;
        assign arr_data = rbank ? mem1[raddr] : mem0[raddr];
`else
        assign arr_data = mem0[raddr];
`endif

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .clock        (clock),
            .rst_n        (rst_n),
            .addr_i       (rd_addr[k*ADDR_W +: ADDR_W]),
            .hold_i       (rd_hold),
`ifdef RF_SHADOW_BANK_EN
            .bank_i       (bank_sel),
            .wr_bank_i    (wr_bank_q),
            .rbank_o      (rbank),
`endif
            .force_zero_i (clearing),
            .wr_valid_i   (wr_valid_q),
            .wr_addr_i    (wr_addr_q),
            .wr_data_i    (wr_data_q),
            .arr_data_i   (arr_data),
            .raddr_o      (raddr),
            .rdata_c_o    (rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: stimulus queues expected values, a monitor compares them.
module tb_rf_multiport;

    logic        clock;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic        rd_hold;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr_req;
    logic        ready;
`ifdef RF_SHADOW_BANK_EN
    logic        bank_sel;
`endif

    rf_multiport dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_hold  (rd_hold),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
`ifdef RF_SHADOW_BANK_EN
        .bank_sel (bank_sel),
`endif
        .ready    (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // kind 0 = read port data, 1 = ready, 2 = write-stage valid
    typedef struct {
        int          kind;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    logic [31:0] act;
    int          checks   = 0;
    int          failures = 0;

    // Monitor: outputs settle after each rising edge and are compared on the falling edge.
    always @(negedge clock) begin
        while (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            case (cur.kind)
                0:       act = rd_data[cur.port*32 +: 32];
                1:       act = {31'b0, ready};
                default: act = {31'b0, dut.wr_valid_q};
            endcase
            checks++;
            if (act !== cur.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", cur.name, act, cur.val);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_rd(input int p, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = 0; e.port = p; e.val = v; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic exp_rdy(input logic v, input string nm);
        exp_t e;
        e.kind = 1; e.port = 0; e.val = {31'b0, v}; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic exp_wv(input logic v, input string nm);
        exp_t e;
        e.kind = 2; e.port = 0; e.val = {31'b0, v}; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic do_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        wr_en = en; wr_addr = a; wr_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rd_hold = 1'b0; clr_req = 1'b0;
        set_rd(5'd0, 5'd0);
        do_wr(1'b0, 5'd0, 32'h0);
`ifdef RF_SHADOW_BANK_EN
        bank_sel = 1'b0;
`endif
        #1;
        exp_rdy(1'b0, "reset_ready");
        exp_rd(0, 32'h0, "reset_rd0");
        exp_rd(1, 32'h0, "reset_rd1");
        exp_wv(1'b0, "reset_wvalid");
        tick();
        rst_n = 1'b1;

        // Sweep of entries 1..31 keeps ready low for 31 cycles.
        exp_rdy(1'b0, "sweep_ready_pre");
        for (int i = 1; i <= 30; i++) begin
            tick();
            exp_rdy(1'b0, "sweep_ready_low");
        end
        tick();
        exp_rdy(1'b1, "sweep_ready_high");

        for (int i = 1; i <= 31; i++) begin
            set_rd(5'(i), 5'(32 - i));
            tick();
            exp_rd(0, 32'h0, "cleared_p0");
            exp_rd(1, 32'h0, "cleared_p1");
        end

        // Write with bypass before commit.
        do_wr(1'b1, 5'd5, 32'hDEADBEEF);
        set_rd(5'd5, 5'd0);
        tick();
        do_wr(1'b0, 5'd0, 32'h0);
        exp_rd(0, 32'hDEADBEEF, "bypass_r5");
        exp_wv(1'b1, "bypass_wvalid");
        tick();
        exp_rd(0, 32'hDEADBEEF, "commit_r5");
        tick();
        exp_rd(0, 32'hDEADBEEF, "hold_r5");

        // r0 protection.
        do_wr(1'b1, 5'd0, 32'hFFFFFFFF);
        set_rd(5'd0, 5'd0);
        tick();
        do_wr(1'b0, 5'd0, 32'h0);
        exp_rd(0, 32'h0, "r0_p0");
        exp_rd(1, 32'h0, "r0_p1");
        exp_wv(1'b0, "r0_wvalid");
        tick();
        exp_rd(0, 32'h0, "r0_after");

        // Back-to-back writes to one address: newest wins.
        do_wr(1'b1, 5'd9, 32'h00000001);
        set_rd(5'd5, 5'd9);
        tick();
        exp_rd(1, 32'h00000001, "b2b_first");
        do_wr(1'b1, 5'd9, 32'h00000099);
        tick();
        do_wr(1'b0, 5'd0, 32'h0);
        exp_rd(1, 32'h00000099, "b2b_second");
        exp_rd(0, 32'hDEADBEEF, "b2b_other_port");
        tick();
        exp_rd(1, 32'h00000099, "b2b_commit");

        // Stall: held address sees a write to it through the bypass.
        set_rd(5'd7, 5'd0);
        tick();
        exp_rd(0, 32'h0, "stall_r7_init");
        rd_hold = 1'b1;
        set_rd(5'd9, 5'd0);
        tick();
        exp_rd(0, 32'h0, "stall_held");
        do_wr(1'b1, 5'd7, 32'h12345678);
        tick();
        do_wr(1'b0, 5'd0, 32'h0);
        exp_rd(0, 32'h12345678, "stall_bypass");
        tick();
        exp_rd(0, 32'h12345678, "stall_commit");
        rd_hold = 1'b0;
        tick();
        exp_rd(0, 32'h00000099, "stall_release_r9");

        // Clear request with a pending write to r3.
        do_wr(1'b1, 5'd3, 32'h000000AA);
        set_rd(5'd3, 5'd5);
        tick();
        do_wr(1'b0, 5'd0, 32'h0);
        exp_rdy(1'b1, "clr_pre_ready");
        exp_rd(0, 32'h000000AA, "clr_pre_bypass");
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        exp_rdy(1'b0, "clr_ready_drop");
        exp_rd(0, 32'h0, "clr_forced_zero");
        exp_wv(1'b0, "clr_wvalid");
        for (int i = 1; i <= 30; i++) begin
            do_wr(i % 3 == 0, 5'd3, 32'h00000055);
            tick();
            exp_rdy(1'b0, "clr_ready_low");
        end
        do_wr(1'b0, 5'd0, 32'h0);
        tick();
        exp_rdy(1'b1, "clr_ready_back");
        exp_rd(0, 32'h0, "clr_r3_zero");
        exp_rd(1, 32'h0, "clr_r5_zero");
        exp_wv(1'b0, "clr_no_stray_write");
        set_rd(5'd7, 5'd9);
        tick();
        exp_rd(0, 32'h0, "clr_r7_zero");
        exp_rd(1, 32'h0, "clr_r9_zero");

        // Normal writes resume after the clear.
        do_wr(1'b1, 5'd3, 32'h00000077);
        set_rd(5'd3, 5'd3);
        tick();
        do_wr(1'b0, 5'd0, 32'h0);
        exp_rd(0, 32'h00000077, "post_clr_bypass_p0");
        exp_rd(1, 32'h00000077, "post_clr_bypass_p1");
        tick();
        exp_rd(0, 32'h00000077, "post_clr_commit");

`ifdef RF_SHADOW_BANK_EN
        do_wr(1'b1, 5'd4, 32'h00000011);
        bank_sel = 1'b0;
        set_rd(5'd4, 5'd0);
        tick();
        exp_rd(0, 32'h00000011, "bank0_bypass");
        do_wr(1'b1, 5'd4, 32'h00000022);
        bank_sel = 1'b1;
        tick();
        do_wr(1'b0, 5'd0, 32'h0);
        exp_rd(0, 32'h00000022, "bank1_bypass");
        tick();
        exp_rd(0, 32'h00000022, "bank1_commit");
        bank_sel = 1'b0;
        tick();
        exp_rd(0, 32'h00000011, "bank0_read");
        rd_hold = 1'b1;
        bank_sel = 1'b1;
        do_wr(1'b1, 5'd4, 32'h00000033);
        tick();
        do_wr(1'b0, 5'd0, 32'h0);
        exp_rd(0, 32'h00000011, "no_cross_bank_bypass");
        rd_hold = 1'b0;
        tick();
        exp_rd(0, 32'h00000033, "bank1_read");
`endif

        tick();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
